dst_param: RTL
==============

// Module: dst_param
// PURPOSE
//   Next-generation display sync timing generator, driven from the pixel clock.
//   Every timing value and sync polarity is a parameter, so one RTL serves any VGA mode.
//   Adds per-axis and combined display enables, pixel coordinates, and frame/line strobes.
//   Generates a down-scaled frame-buffer read address (raddr) one cycle ahead of de,
//   so DDP's synchronous RAM read data lines up with de.
// PARAMETERS
//   H_ACTIVE     800  visible pixels per line
//   H_FP         56   horizontal front porch (pclk)
//   H_SYNC       120  horizontal sync width (pclk)
//   H_BP         64   horizontal back porch (pclk)
//   V_ACTIVE     600  visible lines per frame
//   V_FP         37   vertical front porch (lines)
//   V_SYNC       6    vertical sync width (lines)
//   V_BP         23   vertical back porch (lines)
//   HS_POL       1    hs level during sync pulse (1 = active-high)
//   VS_POL       1    vs level during sync pulse
//   SCALE_SHIFT  2    frame buffer is (H_ACTIVE>>S) x (V_ACTIVE>>S); each texel is 2^S x 2^S pixels
//   DW           15   raddr width; must satisfy 2^DW >= (H_ACTIVE>>S)*(V_ACTIVE>>S)
// PORTS
//   pclk         in   1   pixel clock; the only clock
//   rstn         in   1   synchronous reset, active-low
//   en           in   1   run enable; 0 = timing held in reset state
//   hs           out  1   horizontal sync
//   vs           out  1   vertical sync
//   hen          out  1   horizontal active region
//   ven          out  1   vertical active region
//   de           out  1   hen & ven
//   x            out  12  active pixel column; 0 outside hen
//   y            out  12  active line; 0 outside ven
//   raddr        out  DW  frame-buffer read address; leads de by 1 cycle
//   frame_start  out  1   1-cycle pulse at hcnt=0, vcnt=0
//   line_start   out  1   1-cycle pulse at every hcnt=0
// BEHAVIOUR
//   - Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
//   - hcnt counts 0..H_TOTAL-1 and wraps to 0; vcnt increments on hcnt wrap, 0..V_TOTAL-1.
//   - Region order per axis (counter value):
//       sync  [0, SYNC)
//       bp    [SYNC, SYNC+BP)
//       active[SYNC+BP, SYNC+BP+ACTIVE)
//       fp    rest of the line/frame
//   - Register outputs: hs, vs, hen, ven, de, x, y, frame_start and line_start are
//     registered from the counter stage, giving 1-cycle latency.
//   - x and y are measured from the start of the active region, so the first active pixel is x=0.
//   - raddr is the counter-stage output, 1 cycle ahead of de. It is built incrementally
//     (no multiplier):
//       * row_base clears at frame start.
//       * row_base += H_ACTIVE>>S after every 2^S active lines.
//       * At active-line start, raddr = row_base.
//       * raddr += 1 every 2^S active pixels.
//       * Outside the active area, raddr holds its last value.
//   - Reset (rstn=0 at a pclk edge) or en=0:
//       * hcnt=vcnt=0; hs=~HS_POL, vs=~VS_POL.
//       * hen=ven=de=0, x=y=0, raddr=0, both pulses 0.
//       * Applies mid-frame too, with no partial-line completion.
//       * Restart on en=1 or rstn=1 begins a fresh frame at hcnt=vcnt=0.
//   - Simultaneous line wrap and frame wrap: vcnt goes to 0 and row_base clears in the same cycle.
//     frame_start and line_start then both pulse.
//   - Wrap boundaries:
//       * Last pixel of the last active line: raddr = (H_ACTIVE>>S)*(V_ACTIVE>>S)-1.
//       * raddr never exceeds this value.
// CONFIGURATION
//   DST_TEST_PATTERN_EN
//   - Defined:
//       * Adds output tp_rgb[11:0], registered and aligned with de.
//       * Draws 8 vertical colour bars, each H_ACTIVE/8 wide, in order
//         white F_FF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
//       * tp_rgb = 0 when de=0 and at reset.
//   - Undefined: tp_rgb port and its logic are absent.
// TESTING  (test params: H 8/2/2/2 -> H_TOTAL=14, V 4/1/1/1 -> V_TOTAL=7, S=1, DW=4)
//   1. Release rstn, en=1 -> first hs active for 2 cycles (hcnt 0..1); line period 14 clk;
//      frame period 98 clk; vs active for exactly 14 clk.
//   2. Active window -> de high 8 clk per line on lines vcnt 2..5; x steps 0..7; y steps 0..3.
//   3. raddr sequence over the frame (one value per 2 pixels):
//      line0 0,0,1,1,2,2,3,3; line1 same; line2 4,4,5,5,6,6,7,7; line3 same.
//      Each value appears 1 clk before the matching de cycle.
//   4. Pulse at wrap (hcnt=13, vcnt=6) -> next registered cycle has frame_start=1 and line_start=1;
//      raddr restarts at 0 on the next active line.
//   5. Drop rstn mid-active (x=5, y=2) for 1 clk -> next cycle all outputs at reset values;
//      after release, a full frame is identical to scenario 1.
//   6. DST_TEST_PATTERN_EN with H_ACTIVE=8 -> tp_rgb per active pixel =
//      FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000; 000 whenever de=0.

Source files
------------

// File: rtl/dst_param.sv
// -----------------------------------------------------------------------------
// dst_param - parameterised display sync timing generator (pixel-clock domain)
//
// Purpose
//   Produces horizontal/vertical sync, per-axis and combined display enables,
//   active-area pixel coordinates, frame/line start strobes and a down-scaled
//   frame-buffer read address. raddr comes straight from the counter stage, so
//   it leads the registered de by one clock. This lets a synchronous RAM's read
//   data line up with de.
//
// Ports
//   pclk         in   1   pixel clock, the only clock
//   rstn         in   1   synchronous reset, active-low
//   en           in   1   run enable; 0 holds the timing in its reset state
//   hs, vs       out  1   horizontal / vertical sync (polarity by HS_POL/VS_POL)
//   hen, ven     out  1   horizontal / vertical active region
//   de           out  1   hen & ven
//   x, y         out  12  active column / line, 0 outside the region
//   raddr        out  DW  frame-buffer read address, one cycle ahead of de
//   frame_start  out  1   one-cycle pulse at hcnt=0, vcnt=0
//   line_start   out  1   one-cycle pulse at every hcnt=0
//   tp_rgb       out  12  colour-bar test pattern, aligned with de
//                         (present only with DST_TEST_PATTERN_EN defined)
//
// Configuration
//   DST_TEST_PATTERN_EN : adds tp_rgb with 8 vertical colour bars.
// -----------------------------------------------------------------------------
module dst_param #(
    parameter int   H_ACTIVE    = 800,
    parameter int   H_FP        = 56,
    parameter int   H_SYNC      = 120,
    parameter int   H_BP        = 64,
    parameter int   V_ACTIVE    = 600,
    parameter int   V_FP        = 37,
    parameter int   V_SYNC      = 6,
    parameter int   V_BP        = 23,
    parameter logic HS_POL      = 1'b1,
    parameter logic VS_POL      = 1'b1,
    parameter int   SCALE_SHIFT = 2,
    parameter int   DW          = 15
) (
    input  logic          pclk,
    input  logic          rstn,
    input  logic          en,
    output logic          hs,
    output logic          vs,
    output logic          hen,
    output logic          ven,
    output logic          de,
    output logic [11:0]   x,
    output logic [11:0]   y,
    output logic [DW-1:0] raddr,
    output logic          frame_start,
    output logic          line_start
`ifdef DST_TEST_PATTERN_EN
    ,
    output logic [11:0]   tp_rgb
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
    localparam logic [11:0] H_ACT_LO   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_ACT_HI   = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_ACT_LO   = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_ACT_HI   = 12'(V_SYNC + V_BP + V_ACTIVE);

    // Low SCALE_SHIFT bits of a coordinate select the position inside a texel.
    localparam logic [11:0]   SMASK    = 12'((1 << SCALE_SHIFT) - 1);
    localparam logic [DW-1:0] ROW_STEP = DW'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic [DW-1:0] ONE_DW   = DW'(1);

    // Counter stage
    logic [11:0]   hcnt_q, hcnt_d;
    logic [11:0]   vcnt_q, vcnt_d;
    logic [DW-1:0] row_base_q, row_base_d;
    logic [DW-1:0] raddr_q, raddr_d;

    // Decode of the current counter position
    logic          hs_s, vs_s, hen_s, ven_s, fs_s, ls_s;
    logic [11:0]   x_s, y_s;
    logic          line_wrap_s, frame_wrap_s;

    // Decode of the next counter position (drives raddr)
    logic          hen_n_s, ven_n_s;
    logic [11:0]   x_n_s;

    // Registered outputs
    logic          hs_q, vs_q, hen_q, ven_q, de_q, fs_q, ls_q;
    logic [11:0]   x_q, y_q;

    // Next counter position; en=0 parks the counters at the frame origin.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!en) begin
            hcnt_d = 12'd0;
            vcnt_d = 12'd0;
        end else if (line_wrap_s) begin
            hcnt_d = 12'd0;
            if (frame_wrap_s) begin
                vcnt_d = 12'd0;
            end else begin
                vcnt_d = vcnt_q + 12'd1;
            end
        end else begin
            hcnt_d = hcnt_q + 12'd1;
        end
    end

    // Region decode of the current counter position.
    always_comb begin
        line_wrap_s  = (hcnt_q == H_LAST);
        frame_wrap_s = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
        hs_s  = (hcnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
        vs_s  = (vcnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
        hen_s = (hcnt_q >= H_ACT_LO) && (hcnt_q < H_ACT_HI);
        ven_s = (vcnt_q >= V_ACT_LO) && (vcnt_q < V_ACT_HI);
        fs_s  = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
        ls_s  = (hcnt_q == 12'd0);
        if (hen_s) begin
            x_s = hcnt_q - H_ACT_LO;
        end else begin
            x_s = 12'd0;
        end
        if (ven_s) begin
            y_s = vcnt_q - V_ACT_LO;
        end else begin
            y_s = 12'd0;
        end
    end

    // Region decode of the next counter position, used to pre-compute raddr.
    always_comb begin
        hen_n_s = (hcnt_d >= H_ACT_LO) && (hcnt_d < H_ACT_HI);
        ven_n_s = (vcnt_d >= V_ACT_LO) && (vcnt_d < V_ACT_HI);
        x_n_s   = hcnt_d - H_ACT_LO;
    end

    // Row base: cleared at frame wrap, advanced by one texel row after the
    // last pixel line of each texel row. Frame wrap takes priority so the
    // combined line/frame wrap clears it.
    always_comb begin
        row_base_d = row_base_q;
        if (!en) begin
            row_base_d = '0;
        end else if (frame_wrap_s) begin
            row_base_d = '0;
        end else if (line_wrap_s && ven_s && ((y_s & SMASK) == SMASK)) begin
            row_base_d = row_base_q + ROW_STEP;
        end else begin
            row_base_d = row_base_q;
        end
    end

    // Read address for the next counter position: load row base at the first
    // active pixel, step once per texel column, hold outside the active area.
    always_comb begin
        raddr_d = raddr_q;
        if (!en) begin
            raddr_d = '0;
        end else if (hen_n_s && ven_n_s) begin
            if (hcnt_d == H_ACT_LO) begin
                raddr_d = row_base_d;
            end else if ((x_n_s & SMASK) == 12'd0) begin
                raddr_d = raddr_q + ONE_DW;
            end else begin
                raddr_d = raddr_q;
            end
        end else begin
            raddr_d = raddr_q;
        end
    end

    // Counter-stage state registers.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            hcnt_q     <= 12'd0;
            vcnt_q     <= 12'd0;
            row_base_q <= '0;
            raddr_q    <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            row_base_q <= row_base_d;
            raddr_q    <= raddr_d;
        end
    end

    // Output stage: one-cycle registered copy of the counter-stage decode.
    always_ff @(posedge pclk) begin
        if (!rstn || !en) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            hen_q <= 1'b0;
            ven_q <= 1'b0;
            de_q  <= 1'b0;
            x_q   <= 12'd0;
            y_q   <= 12'd0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            hs_q  <= hs_s;
            vs_q  <= vs_s;
            hen_q <= hen_s;
            ven_q <= ven_s;
            de_q  <= hen_s & ven_s;
            x_q   <= x_s;
            y_q   <= y_s;
            fs_q  <= fs_s;
            ls_q  <= ls_s;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign hen         = hen_q;
    assign ven         = ven_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign raddr       = raddr_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

`ifdef DST_TEST_PATTERN_EN
    localparam int          BAR_W   = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
    localparam logic [11:0] BAR_W12 = 12'(BAR_W);

    logic [11:0] bar_full_s;
    logic [2:0]  bar_s;
    logic [11:0] tp_q;

    // Colour of each of the eight bars, left to right.
    function automatic logic [11:0] tp_colour(input logic [2:0] bar);
        logic [11:0] rgb;
        case (bar)
            3'd0:    rgb = 12'hFFF;
            3'd1:    rgb = 12'hFF0;
            3'd2:    rgb = 12'h0FF;
            3'd3:    rgb = 12'h0F0;
            3'd4:    rgb = 12'hF0F;
            3'd5:    rgb = 12'hF00;
            3'd6:    rgb = 12'h00F;
            3'd7:    rgb = 12'h000;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

    // Bar index of the current column; leftover columns join the last bar.
    always_comb begin
        bar_full_s = x_s / BAR_W12;
        if (bar_full_s > 12'd7) begin
            bar_s = 3'd7;
        end else begin
            bar_s = bar_full_s[2:0];
        end
    end

    // Pattern register, same latency as de; black outside the active area.
    always_ff @(posedge pclk) begin
        if (!rstn || !en) begin
            tp_q <= 12'h000;
        end else if (hen_s && ven_s) begin
            tp_q <= tp_colour(bar_s);
        end else begin
            tp_q <= 12'h000;
        end
    end

    assign tp_rgb = tp_q;
`endif

endmodule
